// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared widths and types for the instruction-fetch controller.
package inst_fetch_ctrl_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam logic [DATA_W-1:0] ZERO_WORD = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } fetch_word_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with combinational head, synchronous clear and occupancy count.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (32'(count) == DEPTH);
    assign do_pop  = pop & ~empty;
    // A full FIFO may still take a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch bus master: gates requests, tags responses with their PC,
// drops responses made stale by a flush and feeds the IF/ID register.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int MAX_OUT   = 2,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ce_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              pc_read_ready_o,
    output logic              inst_req_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    input  logic              inst_addr_ok_i,
    input  logic              inst_data_ok_i,
    input  logic [DATA_W-1:0] inst_rdata_i,
    output logic              id_valid_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [DATA_W-1:0] id_inst_o
);
    localparam int CW = $clog2(MAX_OUT) + 1;
    localparam int BW = $clog2(BUF_DEPTH) + 1;

    logic [CW-1:0]     out_cnt, discard_cnt, out_lim;
    logic              accept, resp, keep_word, take, room;

    logic [ADDR_W-1:0] q_pc;
    logic              q_full, q_empty;
    logic [CW-1:0]     q_count;

    fetch_word_t       buf_head, new_word;
    logic              buf_push, buf_pop, buf_full, buf_empty;
    logic [BW-1:0]     buf_cnt;

    // In the flush cycle the buffer is being emptied and the returning word is
    // retired, so the gating looks at the occupancy left after the flush.
    always_comb begin
        out_lim = out_cnt;
        if (flush_i && resp) out_lim = out_cnt - CW'(1);
        room = flush_i || ((32'(buf_cnt) + 32'(out_cnt)) < BUF_DEPTH);
        inst_req_o = rst & ce_i & ~stall_i & (32'(out_lim) < MAX_OUT) & room;
    end

    assign inst_addr_o     = pc_i;
    assign accept          = inst_req_o & inst_addr_ok_i;
    assign pc_read_ready_o = accept;
    assign resp            = inst_data_ok_i & ~q_empty;
    assign keep_word       = resp & (discard_cnt == '0) & ~flush_i;
    assign new_word        = '{pc: q_pc, inst: inst_rdata_i};
    assign take            = ~stall_i & ~flush_i;
    assign buf_pop         = take & ~buf_empty;
    // With nothing buffered the word goes straight to the output register.
    assign buf_push        = keep_word & ~(take & buf_empty);

    fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(MAX_OUT)) u_pc_q (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (resp),
        .clear (1'b0),
        .din   (pc_i),
        .dout  (q_pc),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    fetch_fifo #(.WIDTH($bits(fetch_word_t)), .DEPTH(BUF_DEPTH)) u_inst_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (buf_push),
        .pop   (buf_pop),
        .clear (flush_i),
        .din   (new_word),
        .dout  (buf_head),
        .full  (buf_full),
        .empty (buf_empty),
        .count (buf_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_cnt     <= '0;
            discard_cnt <= '0;
        end else begin
            out_cnt <= out_cnt + CW'(accept) - CW'(resp);
            if (flush_i)
                discard_cnt <= out_cnt - CW'(resp);
            else if (resp && discard_cnt != '0)
                discard_cnt <= discard_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_valid_o <= 1'b0;
            id_pc_o    <= ZERO_WORD;
            id_inst_o  <= ZERO_WORD;
        end else if (flush_i) begin
            id_valid_o <= 1'b0;
        end else if (!stall_i) begin
            if (!buf_empty) begin
                id_valid_o <= 1'b1;
                id_pc_o    <= buf_head.pc;
                id_inst_o  <= buf_head.inst;
            end else if (keep_word) begin
                id_valid_o <= 1'b1;
                id_pc_o    <= new_word.pc;
                id_inst_o  <= new_word.inst;
            end else begin
                id_valid_o <= 1'b0;
            end
        end
    end

    a_out_cnt:  assert property (@(posedge clk) disable iff (!rst)
                    !(accept && !resp && 32'(out_cnt) == MAX_OUT));
    a_discard:  assert property (@(posedge clk) disable iff (!rst) discard_cnt <= out_cnt);
    a_pc_q:     assert property (@(posedge clk) disable iff (!rst)
                    (q_count == out_cnt) && !(accept && q_full && !resp));
    a_inst_buf: assert property (@(posedge clk) disable iff (!rst)
                    !(buf_push && buf_full && !buf_pop));

endmodule
